pfb_demux_2x_sequencer: RTL and testbench

// - Address/control sequencer for the 2x-oversampled PFB demux sample buffer. Writes each input sample into a ring buffer.
// - Each frame reads NUM_CHANNELS samples, channel NUM_CHANNELS-1 down to 0; frames advance by NUM_CHANNELS/2 samples (hop).
// - Sits between the ADC-side input stream and the buffer RAM / filter datapath; owns occupancy, overflow and gap flags.

---
 rtl/dsp_pkg.sv | 11 +
 rtl/pfb_demux_2x_sequencer.sv | 133 +++++++++++++
 tb/tb_pfb_demux_2x_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: shared types and helpers for the PFB demux datapath
// Contents: pfb_seq_state_t (sequencer FSM states), pfb_hop() (frame advance in samples)
package dsp_pkg;

    typedef enum logic {S_IDLE, S_READ} pfb_seq_state_t;

    function automatic int pfb_hop(input int num_channels);
        return num_channels / 2;
    endfunction

endpackage

// File: rtl/pfb_demux_2x_sequencer.sv
// pfb_demux_2x_sequencer: address/control sequencer for the 2x-oversampled PFB demux ring buffer
// Ports:
//   Clk, Rst_n (async, active low)        clock and reset
//   Input_valid                           one input sample this cycle
//   Wr_en, Wr_addr                        registered buffer write strobe/address
//   Rd_en, Rd_addr, Rd_channel, Rd_last   registered buffer read strobe/address/channel/frame end
//   Error_input_overflow                  pulse: sample dropped, ring full
//   Warning_input_gap                     pulse: no input for GAP_LIMIT cycles
// Option: define PFB_DEMUX_SEQ_GAP_DETECT_EN to build the input gap detector; otherwise Warning_input_gap is 0.
module pfb_demux_2x_sequencer
    import dsp_pkg::*;
#(
    parameter int NUM_CHANNELS        = 32,
    parameter int CHANNEL_INDEX_WIDTH = 5,
    parameter int BUFFER_DEPTH        = 64,
    parameter int ADDR_WIDTH          = 6,
    parameter int GAP_LIMIT           = 64
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic                           Input_valid,
    output logic                           Wr_en,
    output logic [ADDR_WIDTH-1:0]          Wr_addr,
    output logic                           Rd_en,
    output logic [ADDR_WIDTH-1:0]          Rd_addr,
    output logic [CHANNEL_INDEX_WIDTH-1:0] Rd_channel,
    output logic                           Rd_last,
    output logic                           Error_input_overflow,
    output logic                           Warning_input_gap
);

    localparam int HOP = pfb_hop(NUM_CHANNELS);
    localparam logic [ADDR_WIDTH:0] OCC_FULL = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
    localparam logic [ADDR_WIDTH:0] OCC_FRAME = (ADDR_WIDTH+1)'(NUM_CHANNELS);
    localparam logic [ADDR_WIDTH:0] OCC_HOP = (ADDR_WIDTH+1)'(HOP);
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] CH_TOP = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS-1);

    if (NUM_CHANNELS < 4 || BUFFER_DEPTH < NUM_CHANNELS + HOP || (1 << ADDR_WIDTH) != BUFFER_DEPTH ||
        (1 << CHANNEL_INDEX_WIDTH) != NUM_CHANNELS || GAP_LIMIT < 1) begin : g_bad_cfg
        $error("pfb_demux_2x_sequencer: illegal parameter set");
    end

    pfb_seq_state_t                 r_state, w_state_nxt;
    logic [CHANNEL_INDEX_WIDTH-1:0] r_ch, w_ch_nxt;
    logic [ADDR_WIDTH-1:0]          r_wr_ptr, r_frame_base;
    logic [ADDR_WIDTH:0]            r_occ, w_occ_nxt;
    logic                           w_retire, w_accept;
    logic                           r_wr_en, r_rd_en, r_rd_last, r_ovf;
    logic [ADDR_WIDTH-1:0]          r_wr_addr, r_rd_addr;
    logic [CHANNEL_INDEX_WIDTH-1:0] r_rd_channel;

    // A retire in the same cycle frees space, so a full ring still takes the sample
    assign w_retire  = (r_state == S_READ) && (r_ch == '0);
    assign w_accept  = Input_valid && ((r_occ != OCC_FULL) || w_retire);
    assign w_occ_nxt = r_occ + (ADDR_WIDTH+1)'(w_accept) - (w_retire ? OCC_HOP : '0);

    // Frame end checks the occupancy including this cycle's write, so back-to-back frames need no bubble
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = CH_TOP;
        if (r_state == S_IDLE)
            w_state_nxt = (r_occ >= OCC_FRAME) ? S_READ : S_IDLE;
        else begin
            w_state_nxt = (!w_retire || w_occ_nxt >= OCC_FRAME) ? S_READ : S_IDLE;
            w_ch_nxt    = w_retire ? CH_TOP : r_ch - CHANNEL_INDEX_WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_occ        <= '0;
            r_wr_ptr     <= '0;
            r_frame_base <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_channel <= '0;
            r_rd_last    <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ch         <= w_ch_nxt;
            r_occ        <= w_occ_nxt;
            r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(w_accept);
            r_frame_base <= w_retire ? r_frame_base + ADDR_WIDTH'(HOP) : r_frame_base;
            r_wr_en      <= w_accept;
            r_wr_addr    <= r_wr_ptr;
            r_rd_en      <= (r_state == S_READ);
            r_rd_addr    <= (r_state == S_READ) ? r_frame_base + ADDR_WIDTH'(CH_TOP - r_ch) : r_rd_addr;
            r_rd_channel <= (r_state == S_READ) ? r_ch : r_rd_channel;
            r_rd_last    <= w_retire;
            r_ovf        <= Input_valid && !w_accept;
        end
    end

    assign Wr_en                = r_wr_en;
    assign Wr_addr              = r_wr_addr;
    assign Rd_en                = r_rd_en;
    assign Rd_addr              = r_rd_addr;
    assign Rd_channel           = r_rd_channel;
    assign Rd_last              = r_rd_last;
    assign Error_input_overflow = r_ovf;

`ifdef PFB_DEMUX_SEQ_GAP_DETECT_EN
    localparam int GAP_W = $clog2(GAP_LIMIT + 1);

    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_gap_run, r_gap_warn, w_gap_fire;

    // The first sample after reset is always accepted, so any Input_valid starts or re-arms the count
    assign w_gap_fire = r_gap_run && !Input_valid && (r_gap_cnt == GAP_W'(GAP_LIMIT - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_gap_cnt  <= '0;
            r_gap_run  <= 1'b0;
            r_gap_warn <= 1'b0;
        end else begin
            r_gap_cnt  <= Input_valid ? '0 : (r_gap_run ? r_gap_cnt + GAP_W'(1) : r_gap_cnt);
            r_gap_run  <= Input_valid || (r_gap_run && !w_gap_fire);
            r_gap_warn <= w_gap_fire;
        end
    end

    assign Warning_input_gap = r_gap_warn;
`else
    assign Warning_input_gap = 1'b0;
`endif

endmodule

// File: tb/tb_pfb_demux_2x_sequencer.sv
// tb_pfb_demux_2x_sequencer: directed self-checking bench for pfb_demux_2x_sequencer (32 ch, depth 64)
module tb_pfb_demux_2x_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_v = 1'b0;
    logic       wr_en, rd_en, rd_last, ovf, gap;
    logic [5:0] wr_addr, rd_addr;
    logic [4:0] rd_ch;

    int n_chk = 0, n_err = 0;
    int t, rd_cnt, rd_first, rd_lt, rd_bad, wr_cnt, wr_bad, ovf_cnt, ovf_first, ovf_last;
    int gap_cnt, gap_first, gap_last;
    logic found;

    pfb_demux_2x_sequencer dut (
        .Clk(clk), .Rst_n(rst_n), .Input_valid(in_v),
        .Wr_en(wr_en), .Wr_addr(wr_addr),
        .Rd_en(rd_en), .Rd_addr(rd_addr), .Rd_channel(rd_ch), .Rd_last(rd_last),
        .Error_input_overflow(ovf), .Warning_input_gap(gap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        t = 0; rd_cnt = 0; rd_first = -1; rd_lt = -1; rd_bad = 0; wr_cnt = 0; wr_bad = 0;
        ovf_cnt = 0; ovf_first = -1; ovf_last = -1; gap_cnt = 0; gap_first = -1; gap_last = -1;
    endtask

    // Observe outputs (state after the previous edge), then drive the input for the next edge.
    // Read model: read number n is frame n/32, channel 31-n%32, address (16*(n/32) + n%32) mod 64.
    task automatic cyc(input logic v);
        int k, f;
        @(negedge clk);
        if (rd_en) begin
            k = rd_cnt % 32;
            f = rd_cnt / 32;
            if (int'(rd_addr) != (16 * f + k) % 64 || int'(rd_ch) != 31 - k || rd_last != (k == 31))
                rd_bad++;
            if (rd_cnt == 0) rd_first = t;
            rd_lt = t;
            rd_cnt++;
        end else if (rd_last) rd_bad++;
        if (wr_en) begin
            if (int'(wr_addr) != wr_cnt % 64) wr_bad++;
            wr_cnt++;
        end
        if (ovf) begin
            if (ovf_cnt == 0) ovf_first = t;
            ovf_last = t;
            ovf_cnt++;
        end
        if (gap) begin
            if (gap_cnt == 0) gap_first = t;
            gap_last = t;
            gap_cnt++;
        end
        in_v = v;
        t++;
    endtask

    task automatic send(input int n, input int period);
        repeat (n) begin
            cyc(1'b1);
            repeat (period - 1) cyc(1'b0);
        end
    endtask

    task automatic reset_dut();
        in_v = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr();
    endtask

    initial begin
        clr();
        repeat (2) @(negedge clk);
        in_v = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_ch", rd_ch, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_gap", gap, 0);

        reset_dut();
        send(31, 4);
        chk("fill_no_early_rd", rd_cnt, 0);
        send(1, 4);
        repeat (60) cyc(1'b0);
        chk("fill_rd_cnt", rd_cnt, 32);
        chk("fill_rd_first", rd_first, 127);
        chk("fill_rd_end", rd_lt, 158);
        chk("fill_rd_bad", rd_bad, 0);
        chk("fill_wr_cnt", wr_cnt, 32);
        chk("fill_wr_bad", wr_bad, 0);

        reset_dut();
        send(8192, 4);
        repeat (200) cyc(1'b0);
        chk("stream_rd_cnt", rd_cnt, 16352);
        chk("stream_rd_bad", rd_bad, 0);
        chk("stream_wr_cnt", wr_cnt, 8192);
        chk("stream_wr_bad", wr_bad, 0);
        chk("stream_ovf", ovf_cnt, 0);

        reset_dut();
        send(100, 1);
        repeat (100) cyc(1'b0);
        chk("b2b_wr_cnt", wr_cnt, 84);
        chk("b2b_wr_bad", wr_bad, 0);
        chk("b2b_ovf_cnt", ovf_cnt, 16);
        chk("b2b_ovf_first", ovf_first, 81);
        chk("b2b_ovf_last", ovf_last, 96);
        chk("b2b_rd_cnt", rd_cnt, 128);
        chk("b2b_rd_first", rd_first, 34);
        chk("b2b_rd_end", rd_lt, 161);
        chk("b2b_rd_bad", rd_bad, 0);

        reset_dut();
        send(32, 4);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cyc(1'b0);
            if (rd_en === 1'b1 && rd_ch == 5'd17) found = 1'b1;
        end
        chk("midrst_ch17_seen", found, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", rd_en, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        chk("midrst_rd_ch", rd_ch, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr();
        send(31, 4);
        repeat (20) cyc(1'b0);
        chk("midrst_no_rd_31", rd_cnt, 0);
        send(1, 4);
        repeat (60) cyc(1'b0);
        chk("midrst_rd_cnt", rd_cnt, 32);
        chk("midrst_rd_first", rd_first, 147);
        chk("midrst_rd_bad", rd_bad, 0);
        chk("midrst_wr_bad", wr_bad, 0);

        reset_dut();
        repeat (80) cyc(1'b0);
        chk("gap_pre_start", gap_cnt, 0);
        clr();
        send(40, 4);
        repeat (100) cyc(1'b0);
        send(1, 4);
        repeat (80) cyc(1'b0);
`ifdef PFB_DEMUX_SEQ_GAP_DETECT_EN
        chk("gap_cnt", gap_cnt, 2);
        chk("gap_first", gap_first, 221);
        chk("gap_rearm", gap_last, 325);
`else
        chk("gap_off", gap_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
